// File: rtl/dino_pkg.sv
// Shared definitions for the dino controller and the dino sprite renderer:
// state encoding, sprite-select codes, datapath widths and default tuning.
package dino_pkg;

  // Datapath widths: Y math is signed 12 bit, the exported origin is 11 bit.
  localparam int Y_W      = 12;
  localparam int V_W      = 8;
  localparam int DINO_Y_W = 11;
  localparam int SEL_W    = 4;
  localparam int SCORE_W  = 16;

  // Default game tuning (pixels, pixels/frame, frames).
  localparam int DEF_GROUND_Y  = 300;
  localparam int DEF_JUMP_V    = 20;
  localparam int DEF_G         = 1;
  localparam int DEF_RUN_DIV   = 6;
  localparam int DEF_SCORE_DIV = 4;
  localparam int DEF_DEAD_HOLD = 30;

  // Sprite-select codes understood by the renderer.
  localparam logic [SEL_W-1:0] SEL_STAND  = 4'd0;
  localparam logic [SEL_W-1:0] SEL_RUN_A  = 4'd1;
  localparam logic [SEL_W-1:0] SEL_RUN_B  = 4'd2;
  localparam logic [SEL_W-1:0] SEL_DUCK_A = 4'd3;
  localparam logic [SEL_W-1:0] SEL_DUCK_B = 4'd4;
  localparam logic [SEL_W-1:0] SEL_JUMP   = 4'd5;
  localparam logic [SEL_W-1:0] SEL_DEAD   = 4'd6;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RUN  = 3'd1,
    ST_JUMP = 3'd2,
    ST_DUCK = 3'd3,
    ST_DEAD = 3'd4
  } dino_state_e;

  // True in the states where the game clock (score) is live.
  function automatic logic is_running(input dino_state_e s);
    return (s == ST_RUN) || (s == ST_JUMP) || (s == ST_DUCK);
  endfunction

  // Sprite code for a state and leg phase (phase only matters for RUN/DUCK).
  function automatic logic [SEL_W-1:0] sel_code(input dino_state_e s, input logic ph);
    logic [SEL_W-1:0] code;
    case (s)
      ST_RUN:  code = ph ? SEL_RUN_B : SEL_RUN_A;
      ST_DUCK: code = ph ? SEL_DUCK_B : SEL_DUCK_A;
      ST_JUMP: code = SEL_JUMP;
      ST_DEAD: code = SEL_DEAD;
      default: code = SEL_STAND;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/dino_ctrl_rise_latch.sv
// Rising-edge detector with a sticky pending flag. The flag is visible in the
// same cycle as the edge, so an edge coinciding with clr is still seen once.
module rise_latch (
  input  logic clk,
  input  logic rst,
  input  logic d,
  input  logic clr,
  output logic pending
);

  logic d_q;
  logic flag_q;
  logic rise;

  assign rise    = d & ~d_q;
  assign pending = flag_q | rise;

  // Track the previous input level and hold the flag until cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      d_q    <= 1'b0;
      flag_q <= 1'b0;
    end else begin
      d_q    <= d;
      flag_q <= clr ? 1'b0 : (flag_q | rise);
    end
  end

endmodule

// File: rtl/dino_ctrl.sv
// Dino game/motion controller: state machine, vertical physics, leg
// animation phase, score prescaler and post-death hold. Everything advances
// only on frame_tick; all outputs come straight from registers.
//
// Handshake: there is no valid/ready pair here. frame_tick is a one-cycle
// strobe that is always accepted; jump is edge-captured every clk and the
// capture is consumed (or dropped) on the next frame_tick.
module dino_ctrl
  import dino_pkg::*;
#(
  parameter int GROUND_Y  = DEF_GROUND_Y,
  parameter int JUMP_V    = DEF_JUMP_V,
  parameter int G         = DEF_G,
  parameter int RUN_DIV   = DEF_RUN_DIV,
  parameter int SCORE_DIV = DEF_SCORE_DIV,
  parameter int DEAD_HOLD = DEF_DEAD_HOLD
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                frame_tick,
  input  logic                jump,
  input  logic                duck,
  input  logic                hit,
  output logic [DINO_Y_W-1:0] dino_y,
  output logic [SEL_W-1:0]    dino_sel,
  output logic                running,
  output logic                dead,
  output logic [SCORE_W-1:0]  score,
  output dino_state_e         state_dbg
);

  localparam int LEG_W  = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
  localparam int PRE_W  = (SCORE_DIV > 1) ? $clog2(SCORE_DIV) : 1;
  localparam int HOLD_W = $clog2(DEAD_HOLD + 1);

  localparam logic signed [Y_W-1:0] GROUND_S = Y_W'(GROUND_Y);
  localparam logic signed [V_W-1:0] JUMP_S   = V_W'(JUMP_V);
  localparam logic signed [V_W-1:0] G_S      = V_W'(G);
  localparam logic signed [V_W-1:0] G2_S     = V_W'(2 * G);
  localparam logic [LEG_W-1:0]      LEG_LAST = LEG_W'(RUN_DIV - 1);
  localparam logic [PRE_W-1:0]      PRE_LAST = PRE_W'(SCORE_DIV - 1);
  localparam logic [HOLD_W-1:0]     HOLD_MAX = HOLD_W'(DEAD_HOLD);

  dino_state_e             state_q, state_nxt;
  logic signed [Y_W-1:0]   y_q, y_nxt, y_calc;
  logic signed [V_W-1:0]   v_q, v_nxt, v_fall;
  logic signed [Y_W-1:0]   v_ext;
  logic [LEG_W-1:0]        leg_cnt_q, leg_cnt_nxt;
  logic                    leg_ph_q, leg_ph_nxt;
  logic [PRE_W-1:0]        pre_q, pre_nxt;
  logic [SCORE_W-1:0]      score_q, score_nxt;
  logic [HOLD_W-1:0]       hold_q, hold_nxt;
  logic [SEL_W-1:0]        sel_q, sel_nxt;
  logic                    running_q, running_nxt;
  logic                    dead_q, dead_nxt;
  logic                    jump_pend;

  // Jump edges are captured between ticks; every tick clears the capture.
  rise_latch u_jump_latch (
    .clk     (clk),
    .rst     (rst),
    .d       (jump),
    .clr     (frame_tick),
    .pending (jump_pend)
  );

  // Sign-extend velocity into the Y domain; y grows downwards, v is upward.
  assign v_ext  = {{(Y_W - V_W){v_q[V_W-1]}}, v_q};
  assign y_calc = y_q - v_ext;
  assign v_fall = v_q - (duck ? G2_S : G_S);

  // Next-state, physics and counter updates, evaluated only on frame ticks.
  always_comb begin
    state_nxt   = state_q;
    y_nxt       = y_q;
    v_nxt       = v_q;
    leg_cnt_nxt = leg_cnt_q;
    leg_ph_nxt  = leg_ph_q;
    pre_nxt     = pre_q;
    score_nxt   = score_q;
    hold_nxt    = hold_q;

    if (frame_tick) begin
      unique case (state_q)
        ST_IDLE: begin
          if (jump_pend) begin
            state_nxt = ST_JUMP;
            v_nxt     = JUMP_S;
            score_nxt = '0;
            pre_nxt   = '0;
          end
        end
        ST_RUN: begin
          if (hit) begin
            state_nxt = ST_DEAD;
          end else if (jump_pend) begin
            state_nxt = ST_JUMP;
            v_nxt     = JUMP_S;
          end else if (duck) begin
            state_nxt = ST_DUCK;
          end
        end
        ST_DUCK: begin
          if (hit) begin
            state_nxt = ST_DEAD;
          end else if (jump_pend) begin
            state_nxt = ST_JUMP;
            v_nxt     = JUMP_S;
          end else if (!duck) begin
            state_nxt = ST_RUN;
          end
        end
        ST_JUMP: begin
          // A hit freezes y where it is; otherwise integrate and clamp on landing.
          if (hit) begin
            state_nxt = ST_DEAD;
          end else begin
            v_nxt = v_fall;
            if (y_calc >= GROUND_S) begin
              y_nxt     = GROUND_S;
              v_nxt     = '0;
              state_nxt = duck ? ST_DUCK : ST_RUN;
            end else begin
              y_nxt = y_calc;
            end
          end
        end
        ST_DEAD: begin
          // Jumps are dropped until the hold has fully elapsed.
          if (hold_q < HOLD_MAX) begin
            hold_nxt = hold_q + 1'b1;
          end else if (jump_pend) begin
            state_nxt = ST_RUN;
            y_nxt     = GROUND_S;
            v_nxt     = '0;
            score_nxt = '0;
            pre_nxt   = '0;
            hold_nxt  = '0;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase

      // Entering DEAD restarts the leg animation and the hold timer.
      if (state_nxt == ST_DEAD && state_q != ST_DEAD) begin
        leg_cnt_nxt = '0;
        leg_ph_nxt  = 1'b0;
        hold_nxt    = '0;
        v_nxt       = '0;
      end else if (state_q == ST_RUN || state_q == ST_DUCK) begin
        if (leg_cnt_q == LEG_LAST) begin
          leg_cnt_nxt = '0;
          leg_ph_nxt  = ~leg_ph_q;
        end else begin
          leg_cnt_nxt = leg_cnt_q + 1'b1;
        end
      end

      // Score counts surviving frames; the fatal frame does not score.
      if (is_running(state_q) && state_nxt != ST_DEAD) begin
        if (pre_q == PRE_LAST) begin
          pre_nxt = '0;
          if (score_q != '1) begin
            score_nxt = score_q + 1'b1;
          end
        end else begin
          pre_nxt = pre_q + 1'b1;
        end
      end
    end
  end

  // Registered output decode from the next state.
  always_comb begin
    sel_nxt     = sel_code(state_nxt, leg_ph_nxt);
    running_nxt = is_running(state_nxt);
    dead_nxt    = (state_nxt == ST_DEAD);
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      y_q       <= GROUND_S;
      v_q       <= '0;
      leg_cnt_q <= '0;
      leg_ph_q  <= 1'b0;
      pre_q     <= '0;
      score_q   <= '0;
      hold_q    <= '0;
      sel_q     <= SEL_STAND;
      running_q <= 1'b0;
      dead_q    <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      y_q       <= y_nxt;
      v_q       <= v_nxt;
      leg_cnt_q <= leg_cnt_nxt;
      leg_ph_q  <= leg_ph_nxt;
      pre_q     <= pre_nxt;
      score_q   <= score_nxt;
      hold_q    <= hold_nxt;
      sel_q     <= sel_nxt;
      running_q <= running_nxt;
      dead_q    <= dead_nxt;
    end
  end

  assign dino_y    = y_q[DINO_Y_W-1:0];
  assign dino_sel  = sel_q;
  assign running   = running_q;
  assign dead      = dead_q;
  assign score     = score_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_dino_ctrl.sv
// Self-checking bench for dino_ctrl: reference model feeds an expected queue,
// directed game scenarios plus a randomized tail.
module tb_dino_ctrl;
  import dino_pkg::*;

  localparam int W = 36;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          frame_tick = 1'b0;
  logic          jump = 1'b0;
  logic          duck = 1'b0;
  logic          hit = 1'b0;
  logic [10:0]   dino_y;
  logic [3:0]    dino_sel;
  logic          running;
  logic          dead;
  logic [15:0]   score;
  dino_state_e   state_dbg;

  dino_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .jump       (jump),
    .duck       (duck),
    .hit        (hit),
    .dino_y     (dino_y),
    .dino_sel   (dino_sel),
    .running    (running),
    .dead       (dead),
    .score      (score),
    .state_dbg  (state_dbg)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  // Scoreboard state
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  dino_state_e m_state;
  int m_y, m_v, m_leg, m_ph, m_pre, m_score, m_hold;
  bit m_pend;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [3:0] m_sel();
    case (m_state)
      ST_RUN:  return (m_ph != 0) ? 4'd2 : 4'd1;
      ST_DUCK: return (m_ph != 0) ? 4'd4 : 4'd3;
      ST_JUMP: return 4'd5;
      ST_DEAD: return 4'd6;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [W-1:0] model_vec();
    logic r;
    r = (m_state == ST_RUN) || (m_state == ST_JUMP) || (m_state == ST_DUCK);
    return {3'(m_state), 11'(m_y), m_sel(), r, (m_state == ST_DEAD), 16'(m_score)};
  endfunction

  function automatic logic [W-1:0] dut_vec();
    return {3'(state_dbg), dino_y, dino_sel, running, dead, score};
  endfunction

  task automatic model_reset();
    m_state = ST_IDLE; m_y = 300; m_v = 0; m_leg = 0; m_ph = 0;
    m_pre = 0; m_score = 0; m_hold = 0; m_pend = 0;
  endtask

  // One frame of game behaviour, written from the game rules.
  task automatic model_step(input bit h, input bit dk);
    dino_state_e nxt;
    int yn;
    bit run_now, leg_now;
    nxt     = m_state;
    run_now = (m_state == ST_RUN) || (m_state == ST_JUMP) || (m_state == ST_DUCK);
    leg_now = (m_state == ST_RUN) || (m_state == ST_DUCK);
    case (m_state)
      ST_IDLE: if (m_pend) begin nxt = ST_JUMP; m_v = 20; m_score = 0; m_pre = 0; end
      ST_RUN: begin
        if (h) nxt = ST_DEAD;
        else if (m_pend) begin nxt = ST_JUMP; m_v = 20; end
        else if (dk) nxt = ST_DUCK;
      end
      ST_DUCK: begin
        if (h) nxt = ST_DEAD;
        else if (m_pend) begin nxt = ST_JUMP; m_v = 20; end
        else if (!dk) nxt = ST_RUN;
      end
      ST_JUMP: begin
        if (h) nxt = ST_DEAD;
        else begin
          yn  = m_y - m_v;
          m_v = m_v - (dk ? 2 : 1);
          if (yn >= 300) begin m_y = 300; m_v = 0; nxt = dk ? ST_DUCK : ST_RUN; end
          else m_y = yn;
        end
      end
      default: begin
        if (m_hold < 30) m_hold++;
        else if (m_pend) begin
          nxt = ST_RUN; m_y = 300; m_v = 0; m_score = 0; m_pre = 0; m_hold = 0;
        end
      end
    endcase
    if (nxt == ST_DEAD && m_state != ST_DEAD) begin
      m_leg = 0; m_ph = 0; m_hold = 0; m_v = 0;
    end else if (leg_now) begin
      if (m_leg == 5) begin m_leg = 0; m_ph = 1 - m_ph; end
      else m_leg++;
    end
    if (run_now && nxt != ST_DEAD) begin
      if (m_pre == 3) begin m_pre = 0; if (m_score < 65535) m_score++; end
      else m_pre++;
    end
    m_state = nxt;
    m_pend  = 0;
  endtask

  task automatic compare_head(input string tag);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = exp_q.pop_front();
      check(tag, 64'(dut_vec()), 64'(e));
    end
  endtask

  // Driver tasks: all start and end just after a falling edge.
  task automatic do_reset();
    rst = 1'b1; frame_tick = 1'b0; hit = 1'b0; jump = 1'b0;
    model_reset();
    exp_q.push_back(model_vec());
    @(negedge clk);
    compare_head("reset");
    rst = 1'b0;
  endtask

  task automatic do_tick(input bit h, input bit edge_j);
    frame_tick = 1'b1;
    hit = h;
    if (edge_j) begin jump = 1'b1; m_pend = 1; end
    model_step(h, duck);
    exp_q.push_back(model_vec());
    @(negedge clk);
    frame_tick = 1'b0; hit = 1'b0; jump = 1'b0;
    compare_head("tick");
  endtask

  task automatic pulse_jump();
    jump = 1'b0;
    @(negedge clk);
    jump = 1'b1;
    m_pend = 1;
    @(negedge clk);
    jump = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(model_vec());
      @(negedge clk);
      compare_head("hold");
    end
  endtask

  int land_k;
  bit landed;
  int sc_save;

  initial begin
    @(negedge clk);
    do_reset();
    check("rst_y", 64'(dino_y), 64'(300));
    check("rst_sel", 64'(dino_sel), 64'(0));

    // Idle ticks without input
    for (int i = 0; i < 5; i++) do_tick(1'b0, 1'b0);
    check("idle_state", 64'(state_dbg), 64'(ST_IDLE));
    check("idle_score", 64'(score), 64'(0));

    // Full default jump from IDLE
    pulse_jump();
    do_tick(1'b0, 1'b0);
    check("jump_sel", 64'(dino_sel), 64'(5));
    for (int k = 1; k <= 41; k++) begin
      if (k == 30) pulse_jump();
      do_tick(1'b0, 1'b0);
      if (k == 20 || k == 21) check("apex_y", 64'(dino_y), 64'(90));
      if (k < 41) check("jump_sel", 64'(dino_sel), 64'(5));
    end
    check("land_y", 64'(dino_y), 64'(300));
    check("land_state", 64'(state_dbg), 64'(ST_RUN));
    idle(3);
    for (int i = 0; i < 3; i++) do_tick(1'b0, 1'b0);

    // Fast fall with duck held from jump tick 10
    pulse_jump();
    do_tick(1'b0, 1'b0);
    for (int k = 1; k <= 9; k++) do_tick(1'b0, 1'b0);
    duck = 1'b1;
    landed = 0;
    land_k = 0;
    for (int k = 10; k <= 41 && !landed; k++) begin
      do_tick(1'b0, 1'b0);
      if (state_dbg != ST_JUMP) begin landed = 1; land_k = k; end
    end
    check("fall_landed", 64'(landed), 64'(1));
    check("fall_tick", 64'(land_k), 64'(29));
    check("fall_y", 64'(dino_y), 64'(300));
    check("fall_state", 64'(state_dbg), 64'(ST_DUCK));
    duck = 1'b0;
    do_tick(1'b0, 1'b0);

    // Hit on jump tick 15 with a pending jump
    pulse_jump();
    do_tick(1'b0, 1'b0);
    for (int k = 1; k <= 14; k++) do_tick(1'b0, 1'b0);
    sc_save = m_score;
    pulse_jump();
    do_tick(1'b1, 1'b0);
    check("hit_state", 64'(state_dbg), 64'(ST_DEAD));
    check("hit_sel", 64'(dino_sel), 64'(6));
    check("hit_y", 64'(dino_y), 64'(111));
    check("hit_score", 64'(score), 64'(sc_save));

    // Hold after death, then restart
    for (int k = 1; k <= 30; k++) begin
      if (k == 10) pulse_jump();
      do_tick(1'b0, 1'b0);
      if (k == 10) check("dead_ignore", 64'(state_dbg), 64'(ST_DEAD));
    end
    check("dead_score", 64'(score), 64'(sc_save));
    pulse_jump();
    do_tick(1'b0, 1'b0);
    check("restart_state", 64'(state_dbg), 64'(ST_RUN));
    check("restart_score", 64'(score), 64'(0));
    check("restart_y", 64'(dino_y), 64'(300));

    // Leg animation and score while running
    for (int k = 1; k <= 24; k++) begin
      do_tick(1'b0, 1'b0);
      check("leg_sel", 64'(dino_sel), 64'(((k / 6) % 2 != 0) ? 2 : 1));
    end
    check("run_score", 64'(score), 64'(6));
    duck = 1'b1;
    do_tick(1'b0, 1'b0);
    check("duck_sel", 64'(dino_sel), 64'(3));
    duck = 1'b0;
    do_tick(1'b0, 1'b0);

    // Jump edge in the tick cycle itself, then reset mid-jump
    do_tick(1'b0, 1'b1);
    check("same_cycle_jump", 64'(state_dbg), 64'(ST_JUMP));
    for (int k = 0; k < 5; k++) do_tick(1'b0, 1'b0);
    do_reset();
    check("midjump_rst", 64'(state_dbg), 64'(ST_IDLE));
    check("midjump_rst_y", 64'(dino_y), 64'(300));

    // Randomized play
    for (int i = 0; i < 250; i++) begin
      case ($urandom_range(0, 9))
        0, 1: pulse_jump();
        2: begin idle(1); do_tick(1'b0, 1'b1); end
        3: duck = ~duck;
        4: idle($urandom_range(1, 3));
        default: do_tick($urandom_range(0, 15) == 0, 1'b0);
      endcase
    end
    duck = 1'b0;
    do_reset();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
